// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential shift-add multiplier, one multiplier bit per cycle
// Signed mode multiplies magnitudes and negates at completion; optional early exit on exhausted multiplier.
module shift_add_mult #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_next;
  logic [WIDTH:0]       acc, acc_next;
  logic [WIDTH-1:0]     mq, mq_next;
  logic [WIDTH-1:0]     mcand, mcand_next;
  logic                 neg, neg_next;
  logic [CW-1:0]        count, count_next;
  logic [2*WIDTH-1:0]   product_next;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     shifted;
  logic [CW:0]          shifts_done;
  logic [CW:0]          shift_amt;
  logic [WIDTH-1:0]     rem_mask;
  logic [2*WIDTH-1:0]   raw;
  logic                 last_full, last_early;

  // Magnitude of the most negative value wraps to 2^(W-1), which is exactly right as unsigned.
  assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

  assign sum         = acc + {1'b0, (mq[0] ? mcand : '0)};
  assign shifted     = {sum, mq} >> 1;
  assign shifts_done = {1'b0, count} + (CW+1)'(1);
  assign shift_amt   = (CW+1)'(WIDTH) - shifts_done;

  // Low W-shifts_done bits of mq still hold unconsumed multiplier bits.
  assign rem_mask   = {WIDTH{1'b1}} >> shifts_done;
  assign last_full  = (count == CW'(WIDTH-1));
  assign last_early = EARLY_EXIT && ((shifted[WIDTH-1:0] & rem_mask) == '0);

  // Skipped iterations only shift, so applying them at once gives the same result.
  assign raw = shifted[2*WIDTH-1:0] >> shift_amt;

  always_comb begin
    state_next   = state;
    acc_next     = acc;
    mq_next      = mq;
    mcand_next   = mcand;
    neg_next     = neg;
    count_next   = count;
    product_next = product;
    busy         = (state == RUN);
    done         = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          mcand_next = a_mag;
          mq_next    = b_mag;
          acc_next   = '0;
          count_next = '0;
          neg_next   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next   = shifted[2*WIDTH:WIDTH];
        mq_next    = shifted[WIDTH-1:0];
        count_next = count + CW'(1);
        if (last_full || last_early) begin
          product_next = neg ? -raw : raw;
          state_next   = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mq      <= '0;
      mcand   <= '0;
      neg     <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      mq      <= mq_next;
      mcand   <= mcand_next;
      neg     <= neg_next;
      count   <= count_next;
      product <= product_next;
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - bench for shift_add_mult across widths 32/8/13 and both exit modes
// Reference model: plain multiply plus done-latency formula, compared every cycle.
module tb_shift_add_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st [5];
  logic        sm [5];
  logic [63:0] av [5];
  logic [63:0] bv [5];

  logic [63:0]  p0, p1;
  logic [15:0]  p2;
  logic [25:0]  p3, p4;
  logic [4:0]   busy_w, done_w;
  logic [127:0] prod_a [5];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  shift_add_mult #(.WIDTH(32), .EARLY_EXIT(1'b0)) u0 (.clk(clk), .rst(rst), .start(st[0]), .signed_mode(sm[0]),
    .a(av[0][31:0]), .b(bv[0][31:0]), .product(p0), .busy(busy_w[0]), .done(done_w[0]));
  shift_add_mult #(.WIDTH(32), .EARLY_EXIT(1'b1)) u1 (.clk(clk), .rst(rst), .start(st[1]), .signed_mode(sm[1]),
    .a(av[1][31:0]), .b(bv[1][31:0]), .product(p1), .busy(busy_w[1]), .done(done_w[1]));
  shift_add_mult #(.WIDTH(8), .EARLY_EXIT(1'b0)) u2 (.clk(clk), .rst(rst), .start(st[2]), .signed_mode(sm[2]),
    .a(av[2][7:0]), .b(bv[2][7:0]), .product(p2), .busy(busy_w[2]), .done(done_w[2]));
  shift_add_mult #(.WIDTH(13), .EARLY_EXIT(1'b0)) u3 (.clk(clk), .rst(rst), .start(st[3]), .signed_mode(sm[3]),
    .a(av[3][12:0]), .b(bv[3][12:0]), .product(p3), .busy(busy_w[3]), .done(done_w[3]));
  shift_add_mult #(.WIDTH(13), .EARLY_EXIT(1'b1)) u4 (.clk(clk), .rst(rst), .start(st[4]), .signed_mode(sm[4]),
    .a(av[4][12:0]), .b(bv[4][12:0]), .product(p4), .busy(busy_w[4]), .done(done_w[4]));

  always_comb begin
    prod_a[0] = {64'd0, p0};
    prod_a[1] = {64'd0, p1};
    prod_a[2] = {112'd0, p2};
    prod_a[3] = {102'd0, p3};
    prod_a[4] = {102'd0, p4};
  end

  function automatic int w_of(int i);
    case (i)
      0, 1:    return 32;
      2:       return 8;
      default: return 13;
    endcase
  endfunction

  function automatic bit ee_of(int i);
    return (i == 1) || (i == 4);
  endfunction

  // Operand value as a 128-bit two's-complement integer.
  function automatic logic [127:0] sx(logic [63:0] v, int w, bit s);
    logic [127:0] r;
    r = {64'd0, v} & ((128'd1 << w) - 128'd1);
    if (s && r[w-1]) r = r - (128'd1 << w);
    return r;
  endfunction

  function automatic logic [127:0] ref_mul(int i, logic [63:0] x, logic [63:0] y, bit s);
    int w;
    w = w_of(i);
    return (sx(x, w, s) * sx(y, w, s)) & ((128'd1 << (2*w)) - 128'd1);
  endfunction

  function automatic int lat_of(int i, logic [63:0] y, bit s);
    logic [127:0] mag;
    int k;
    if (!ee_of(i)) return w_of(i);
    mag = sx(y, w_of(i), s);
    if (mag[127]) mag = -mag;
    k = 1;
    for (int j = 0; j < w_of(i); j++) if (mag[j]) k = j + 1;
    return k;
  endfunction

  int           m_rem  [5];
  bit           m_done [5];
  logic [127:0] m_prod [5];
  logic [127:0] m_pend [5];

  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      int r;
      bit d;
      logic [127:0] p, pd;
      r = m_rem[i]; d = m_done[i]; p = m_prod[i]; pd = m_pend[i];
      if (rst) begin
        r = 0; d = 1'b0; p = '0;
      end else if (d) begin
        d = 1'b0;
      end else if (r > 0) begin
        r = r - 1;
        if (r == 0) begin
          p = pd; d = 1'b1;
        end
      end else if (st[i]) begin
        r  = lat_of(i, bv[i], sm[i]);
        pd = ref_mul(i, av[i], bv[i], sm[i]);
      end
      m_rem[i]  <= r;
      m_done[i] <= d;
      m_prod[i] <= p;
      m_pend[i] <= pd;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (busy_w[i] !== (m_rem[i] > 0) || done_w[i] !== m_done[i] || prod_a[i] !== m_prod[i]) begin
          fails++;
          $display("FAIL model dut%0d: busy=%b done=%b product=%h, expected busy=%b done=%b product=%h",
                   i, busy_w[i], done_w[i], prod_a[i], (m_rem[i] > 0), m_done[i], m_prod[i]);
        end
      end
    end
  end

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(int i, logic [63:0] x, logic [63:0] y, bit s, logic [127:0] exp_p, int exp_k, bit noise);
    int lat;
    @(negedge clk);
    av[i] = x; bv[i] = y; sm[i] = s; st[i] = 1'b1;
    @(negedge clk);
    st[i] = noise;
    if (noise) begin
      av[i] = {$urandom, $urandom}; bv[i] = {$urandom, $urandom};
    end
    lat = 0;
    while (!done_w[i] && lat < 200) begin
      @(negedge clk);
      lat++;
      if (noise) begin
        av[i] = {$urandom, $urandom}; bv[i] = {$urandom, $urandom}; st[i] = 1'b1;
      end
    end
    chk($sformatf("dut%0d latency %h*%h", i, x, y), 128'(lat), 128'(exp_k));
    chk($sformatf("dut%0d product %h*%h", i, x, y), prod_a[i], exp_p);
    @(negedge clk);
    st[i] = 1'b0;
    chk($sformatf("dut%0d done width", i), 128'(done_w[i]), 128'd0);
    chk($sformatf("dut%0d product hold", i), prod_a[i], exp_p);
  endtask

  initial begin
    int q[$];
    bit seen;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      st[i] = 1'b0; sm[i] = 1'b0; av[i] = '0; bv[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("reset product dut%0d", i), prod_a[i], '0);
      chk($sformatf("reset busy dut%0d", i), 128'(busy_w[i]), '0);
      chk($sformatf("reset done dut%0d", i), 128'(done_w[i]), '0);
    end

    run_op(0, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 128'hFFFFFFFE00000001, 32, 1'b0);
    @(negedge clk);
    av[0] = 64'hFFFFFFFF; bv[0] = 64'hFFFFFFFF; sm[0] = 1'b0; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort product", prod_a[0], '0);
    chk("abort busy", 128'(busy_w[0]), '0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= done_w[0];
    end
    chk("abort no done", 128'(seen), '0);

    run_op(0, 64'h80000000, 64'h80000000, 1'b1, 128'h4000000000000000, 32, 1'b0);
    run_op(0, 64'hFFFFFFFD, 64'h7,        1'b1, 128'hFFFFFFFFFFFFFFEB, 32, 1'b0);
    run_op(0, 64'h80000000, 64'h1,        1'b1, 128'hFFFFFFFF80000000, 32, 1'b0);
    run_op(2, 64'hFF, 64'hFF, 1'b0, 128'hFE01, 8, 1'b0);
    run_op(2, 64'h00, 64'hA5, 1'b0, 128'h0, 8, 1'b0);
    run_op(3, 64'h1FFF, 64'h1FFF, 1'b0, 128'h3FFC001, 13, 1'b0);
    run_op(4, 64'h1000, 64'h1000, 1'b1, 128'h1000000, 13, 1'b0);
    run_op(1, 64'd123, 64'd0, 1'b0, 128'd0, 1, 1'b0);
    run_op(1, 64'd9, 64'd5, 1'b0, 128'd45, 3, 1'b0);
    run_op(1, 64'd3, 64'h80000000, 1'b0, 128'h180000000, 32, 1'b0);
    run_op(1, 64'hFFFFFFFD, 64'hFFFFFFFE, 1'b1, 128'd6, 2, 1'b0);
    run_op(0, 64'd5, 64'd7, 1'b0, 128'd35, 32, 1'b1);

    @(negedge clk);
    av[2] = 64'hFF; bv[2] = 64'hFF; sm[2] = 1'b0; st[2] = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (done_w[2]) q.push_back(c);
    end
    st[2] = 1'b0;
    chk("held start op count", 128'(q.size()), 128'd4);
    for (int j = 1; j < q.size(); j++)
      chk($sformatf("held start period %0d", j), 128'(q[j] - q[j-1]), 128'd10);
    repeat (12) @(negedge clk);

    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        st[i] = 1'($urandom_range(0, 1));
        sm[i] = 1'($urandom_range(0, 1));
        av[i] = ($urandom_range(0, 7) == 0) ? (64'd1 << (w_of(i) - 1)) : {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0:       bv[i] = {$urandom, $urandom} >> $urandom_range(0, 63);
          1:       bv[i] = '0;
          2:       bv[i] = 64'd1 << $urandom_range(0, 63);
          default: bv[i] = {$urandom, $urandom};
        endcase
      end
    end
    for (int i = 0; i < 5; i++) st[i] = 1'b0;
    repeat (40) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Parametrised sequential shift-add multiplier, the next generation of the fixed 32-bit adder/shifter/partial-product multiplier datapath. It takes two WIDTH-bit operands on a start pulse and produces a 2*WIDTH-bit product one multiplier bit per cycle. It adds signed (two's-complement) mode and optional early termination. It sits behind the same start/done controller handshake and replaces the separate fsm/regfile/adder/shifter assembly with one self-contained block.

## Interface
- WIDTH, 32, operand width in bits; legal range 4..64.
- EARLY_EXIT, 0, when 1 the block finishes as soon as the remaining multiplier bits are all zero.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  0 = unsigned x unsigned, 1 = signed x signed; captured with start.
- a  input  WIDTH  multiplicand; captured with start.
- b  input  WIDTH  multiplier; captured with start.
- product  output  2*WIDTH  result register; holds the last result until the next completion or reset.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when product becomes valid.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE: if start=1 at a rising edge, capture signed_mode, the magnitudes |a| and |b| (the raw values when signed_mode=0), and the result sign neg = a[W-1]^b[W-1] (0 when unsigned). Clear acc (WIDTH+1 bits), load mq = |b|, set count = 0, go to RUN. Otherwise stay in IDLE.
- RUN, each edge: sum = acc[W-1:0] + (mq[0] ? |a| : 0), giving W+1 bits. {acc, mq} <= {sum, mq} >> 1, so the carry enters the top. count <= count+1.
- RUN exit: leave after count reaches WIDTH-1 on this edge. With EARLY_EXIT=1, also leave when the shifted mq is all zero on this edge; any remaining shifts are applied in one step, so the result is identical.
- On RUN exit, at the same edge: product <= neg ? -(raw 2W result) : raw 2W result. Go to DONE.
- DONE: done=1 for exactly this cycle. The next edge returns to IDLE unconditionally. start in DONE is ignored.
- start while in RUN or DONE is ignored. The operation in flight is unaffected.
- Arithmetic: |x| of -2^(W-1) is 2^(W-1). It is representable as a W-bit unsigned value, so there is no overflow.
  - Signed result range: -2^(2W-2)+2^(W-1) .. 2^(2W-2), which fits in 2W two's-complement bits.
  - Unsigned maximum: (2^W-1)^2, which fits in 2W bits.
- Operand inputs may change freely after the start edge.

## Timing
- Reset values: product=0, done=0, busy=0, state=IDLE, acc/mq/count=0.
- rst=1 at any edge, including mid-RUN or in DONE, aborts the operation. Outputs take their reset values at that edge and no done is issued. rst takes priority over start.
- Let start be accepted at edge N.
- busy is high from after edge N until the exit edge.
- EARLY_EXIT=0: exit edge is N+WIDTH. done is high between edges N+WIDTH and N+WIDTH+1. Latency is WIDTH+1 cycles.
- EARLY_EXIT=1: exit edge is N+k, where k = max(1, index of the highest set bit of |b| + 1). b=0 gives k=1 and done after edge N+1.
- Earliest next acceptance: edge N+WIDTH+2 with EARLY_EXIT=0, or N+k+2 with EARLY_EXIT=1. Back-to-back throughput is therefore one operation every WIDTH+2 cycles.
- product changes only at exit edges and at reset. It stays stable through IDLE and RUN.

## Test plan
- Reset mid-RUN:
  - Stimulus: WIDTH=32, unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF.
  - Required: product=0xFFFFFFFE00000001 with done at start+33. Then restart the same operation and assert rst at start+10: product=0, busy=0, and no done.
- Signed corner cases, WIDTH=32, signed_mode=1:
  - a=0x80000000, b=0x80000000 -> product=0x4000000000000000.
  - a=-3, b=7 -> product=0xFFFFFFFFFFFFFFEB.
  - a=0x80000000, b=1 -> product=0xFFFFFFFF80000000.
- Unsigned at WIDTH=8:
  - a=0xFF, b=0xFF -> product=0xFE01, done at start+9.
  - a=0x00, b=0xA5 -> product=0x0000.
- Early exit, WIDTH=32, EARLY_EXIT=1:
  - b=0 -> done at start+2.
  - b=0x00000005, a=9 -> product=45, done at start+4.
  - b=0x80000000 -> done at start+33.
- Handshake:
  - start held high continuously -> one operation every WIDTH+2 cycles.
  - start pulses during RUN and during DONE are ignored; product equals the first operands' result.
  - done is exactly one cycle wide.
- Randomised: 10k random a, b, signed_mode and both EARLY_EXIT values at WIDTH=32 and WIDTH=13. Check product against a reference multiply and check the latency formula on every operation.
